// File: rtl/cva6_refill_rd_arbiter.sv
// Shares one AXI4 read channel between the icache (port 0) and the data cache (port 1).
// Round-robin AR issue, per-port in-flight limits, R beats steered by the ID MSB.
module cva6_refill_rd_arbiter #(
  parameter int AddrWidth      = 64,
  parameter int DataWidth      = 64,
  parameter int IdWidth        = 4,
  parameter int LenWidth       = 8,
  parameter int MaxOutstanding = 7
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [1:0]                 req_valid_i,
  output logic [1:0]                 req_ready_o,
  input  logic [2*AddrWidth-1:0]     req_addr_i,
  input  logic [2*(IdWidth-1)-1:0]   req_id_i,
  input  logic [2*LenWidth-1:0]      req_len_i,
  output logic                       ar_valid_o,
  input  logic                       ar_ready_i,
  output logic [AddrWidth-1:0]       ar_addr_o,
  output logic [IdWidth-1:0]         ar_id_o,
  output logic [LenWidth-1:0]        ar_len_o,
  input  logic                       r_valid_i,
  output logic                       r_ready_o,
  input  logic [IdWidth-1:0]         r_id_i,
  input  logic                       r_last_i,
  output logic [1:0]                 rsp_valid_o,
  input  logic [1:0]                 rsp_ready_i,
  input  logic                       flush_i,
  output logic                       drained_o,
  output logic                       err_o
);

  localparam int CntW = $clog2(MaxOutstanding + 1);

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e                 state_reg, state_next;
  logic                   rr_ptr_reg, rr_ptr_next;
  logic                   ar_port_reg;
  logic [AddrWidth-1:0]   ar_addr_reg;
  logic [IdWidth-2:0]     ar_id_reg;
  logic [LenWidth-1:0]    ar_len_reg;
  logic [1:0][CntW-1:0]   cnt_reg;
  logic                   err_reg;

  logic [1:0] eligible;
  logic [1:0] cnt_inc;
  logic [1:0] cnt_dec;
  logic [1:0] zero_beat;
  logic       grant_valid;
  logic       grant_port;
  logic       load;
  logic       r_port;
  logic       r_beat;

  assign r_port = r_id_i[IdWidth-1];
  assign r_beat = r_valid_i & r_ready_o;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign eligible[gi]  = req_valid_i[gi] & (cnt_reg[gi] < CntW'(MaxOutstanding)) & ~flush_i;
      assign cnt_inc[gi]   = ar_valid_o & ar_ready_i & (ar_port_reg == 1'(gi));
      // A last beat with nothing outstanding is an error, not a decrement.
      assign cnt_dec[gi]   = r_beat & r_last_i & (r_port == 1'(gi)) & (cnt_reg[gi] != '0);
      assign zero_beat[gi] = r_beat & (r_port == 1'(gi)) & (cnt_reg[gi] == '0);
    end
  endgenerate

  assign grant_valid = |eligible;
  assign grant_port  = eligible[rr_ptr_reg] ? rr_ptr_reg : ~rr_ptr_reg;

  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    req_ready_o = 2'b00;
    ar_valid_o  = 1'b0;
    load        = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (grant_valid) begin
          req_ready_o[grant_port] = 1'b1;
          load                    = 1'b1;
          state_next              = ISSUE;
        end
      end
      ISSUE: begin
        // Once raised, AR stays up until the handshake regardless of flush_i.
        ar_valid_o = 1'b1;
        if (ar_ready_i) begin
          rr_ptr_next = ~ar_port_reg;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg   <= IDLE;
      rr_ptr_reg  <= 1'b0;
      ar_port_reg <= 1'b0;
      ar_addr_reg <= '0;
      ar_id_reg   <= '0;
      ar_len_reg  <= '0;
      cnt_reg     <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      if (load) begin
        ar_port_reg <= grant_port;
        ar_addr_reg <= grant_port ? req_addr_i[2*AddrWidth-1:AddrWidth] : req_addr_i[AddrWidth-1:0];
        ar_id_reg   <= grant_port ? req_id_i[2*(IdWidth-1)-1:IdWidth-1] : req_id_i[IdWidth-2:0];
        ar_len_reg  <= grant_port ? req_len_i[2*LenWidth-1:LenWidth] : req_len_i[LenWidth-1:0];
      end
      for (int i = 0; i < 2; i++) begin
        if (cnt_inc[i] && !cnt_dec[i]) begin
          cnt_reg[i] <= cnt_reg[i] + 1'b1;
        end else if (cnt_dec[i] && !cnt_inc[i]) begin
          cnt_reg[i] <= cnt_reg[i] - 1'b1;
        end
      end
      if (|zero_beat) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign ar_addr_o   = ar_addr_reg;
  assign ar_id_o     = {ar_port_reg, ar_id_reg};
  assign ar_len_o    = ar_len_reg;
  assign rsp_valid_o = r_port ? {r_valid_i, 1'b0} : {1'b0, r_valid_i};
  assign r_ready_o   = rsp_ready_i[r_port];
  assign drained_o   = flush_i & (cnt_reg[0] == '0) & (cnt_reg[1] == '0) & (state_reg == IDLE);
  assign err_o       = err_reg;

endmodule

// File: tb/tb_cva6_refill_rd_arbiter.sv
// Directed bench for the refill read arbiter: issue latency, round robin, limits,
// AR stability, flush/drain and the zero-outstanding error flag.
module tb_cva6_refill_rd_arbiter;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic [1:0]   req_valid_i;
  logic [1:0]   req_ready_o;
  logic [127:0] req_addr_i;
  logic [5:0]   req_id_i;
  logic [15:0]  req_len_i;
  logic         ar_valid_o;
  logic         ar_ready_i;
  logic [63:0]  ar_addr_o;
  logic [3:0]   ar_id_o;
  logic [7:0]   ar_len_o;
  logic         r_valid_i;
  logic         r_ready_o;
  logic [3:0]   r_id_i;
  logic         r_last_i;
  logic [1:0]   rsp_valid_o;
  logic [1:0]   rsp_ready_i;
  logic         flush_i;
  logic         drained_o;
  logic         err_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  cva6_refill_rd_arbiter dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .req_id_i    (req_id_i),
    .req_len_i   (req_len_i),
    .ar_valid_o  (ar_valid_o),
    .ar_ready_i  (ar_ready_i),
    .ar_addr_o   (ar_addr_o),
    .ar_id_o     (ar_id_o),
    .ar_len_o    (ar_len_o),
    .r_valid_i   (r_valid_i),
    .r_ready_o   (r_ready_o),
    .r_id_i      (r_id_i),
    .r_last_i    (r_last_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .flush_i     (flush_i),
    .drained_o   (drained_o),
    .err_o       (err_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni      = 1'b0;
    req_valid_i = 2'b00;
    req_addr_i  = '0;
    req_id_i    = '0;
    req_len_i   = '0;
    ar_ready_i  = 1'b0;
    r_valid_i   = 1'b0;
    r_id_i      = '0;
    r_last_i    = 1'b0;
    rsp_ready_i = 2'b00;
    flush_i     = 1'b0;
    step();
    step();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_ni = 1'b0;
    #1;
    n_cmp++; if (ar_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_ar_valid: got %b want 0", ar_valid_o); end
    n_cmp++; if (req_ready_o !== 2'b00) begin n_bad++; $display("FAIL reset_req_ready: got %b want 00", req_ready_o); end
    n_cmp++; if (rsp_valid_o !== 2'b00) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid_o); end
    n_cmp++; if (r_ready_o !== 1'b0) begin n_bad++; $display("FAIL reset_r_ready: got %b want 0", r_ready_o); end
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err_o); end
    step();
    rst_ni = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_single();
    do_reset();
    req_addr_i[63:0] = 64'h0000_0000_8000_0000;
    req_id_i[2:0]    = 3'd3;
    req_len_i[7:0]   = 8'd1;
    req_valid_i      = 2'b01;
    #1;
    n_cmp++; if (req_ready_o !== 2'b01) begin n_bad++; $display("FAIL single_req_ready: got %b want 01", req_ready_o); end
    n_cmp++; if (ar_valid_o !== 1'b0) begin n_bad++; $display("FAIL single_ar_early: got %b want 0", ar_valid_o); end
    step();
    req_valid_i = 2'b00;
    #1;
    n_cmp++; if (ar_valid_o !== 1'b1) begin n_bad++; $display("FAIL single_ar_valid: got %b want 1", ar_valid_o); end
    n_cmp++; if (ar_id_o !== 4'h3) begin n_bad++; $display("FAIL single_ar_id: got %h want 3", ar_id_o); end
    n_cmp++; if (ar_addr_o !== 64'h8000_0000) begin n_bad++; $display("FAIL single_ar_addr: got %h want 80000000", ar_addr_o); end
    n_cmp++; if (ar_len_o !== 8'd1) begin n_bad++; $display("FAIL single_ar_len: got %h want 01", ar_len_o); end
    ar_ready_i = 1'b1;
    step();
    ar_ready_i  = 1'b0;
    r_valid_i   = 1'b1;
    r_id_i      = 4'h3;
    r_last_i    = 1'b0;
    rsp_ready_i = 2'b01;
    #1;
    n_cmp++; if (ar_valid_o !== 1'b0) begin n_bad++; $display("FAIL single_ar_drop: got %b want 0", ar_valid_o); end
    n_cmp++; if (rsp_valid_o !== 2'b01) begin n_bad++; $display("FAIL single_rsp_valid: got %b want 01", rsp_valid_o); end
    n_cmp++; if (r_ready_o !== 1'b1) begin n_bad++; $display("FAIL single_r_ready: got %b want 1", r_ready_o); end
    step();
    r_last_i = 1'b1;
    step();
    r_valid_i = 1'b0;
    r_last_i  = 1'b0;
    flush_i   = 1'b1;
    #1;
    n_cmp++; if (drained_o !== 1'b1) begin n_bad++; $display("FAIL single_cnt0_zero: drained got %b want 1", drained_o); end
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL single_err: got %b want 0", err_o); end
    flush_i = 1'b0;
    $display("test_single done");
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_id [4];
    int n;
    exp_id[0] = 4'h2; exp_id[1] = 4'hd; exp_id[2] = 4'h2; exp_id[3] = 4'hd;
    do_reset();
    req_id_i    = {3'd5, 3'd2};
    req_addr_i  = {64'h2000, 64'h1000};
    req_valid_i = 2'b11;
    ar_ready_i  = 1'b1;
    n = 0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      #1;
      if (ar_valid_o) begin
        n_cmp++;
        if (ar_id_o !== exp_id[n]) begin n_bad++; $display("FAIL rr_ar_id[%0d]: got %h want %h", n, ar_id_o, exp_id[n]); end
        n++;
      end
      step();
    end
    n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL rr_count: got %0d want 4", n); end
    req_valid_i = 2'b00;
    ar_ready_i  = 1'b0;
    $display("test_round_robin done");
  endtask

  task automatic test_outstanding_limit();
    int hs;
    do_reset();
    req_id_i    = '0;
    req_valid_i = 2'b10;
    ar_ready_i  = 1'b1;
    hs = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (ar_valid_o && ar_ready_i) hs++;
      step();
    end
    n_cmp++; if (hs !== 7) begin n_bad++; $display("FAIL limit_issued: got %0d want 7", hs); end
    n_cmp++; if (req_ready_o !== 2'b00) begin n_bad++; $display("FAIL limit_blocked: got %b want 00", req_ready_o); end
    r_valid_i   = 1'b1;
    r_id_i      = 4'h8;
    r_last_i    = 1'b1;
    rsp_ready_i = 2'b10;
    step();
    r_valid_i = 1'b0;
    r_last_i  = 1'b0;
    hs = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (ar_valid_o && ar_ready_i) hs++;
      step();
    end
    n_cmp++; if (hs !== 1) begin n_bad++; $display("FAIL limit_eighth: got %0d want 1", hs); end
    req_valid_i = 2'b00;
    ar_ready_i  = 1'b0;
    $display("test_outstanding_limit done");
  endtask

  task automatic test_ar_stable();
    do_reset();
    req_addr_i[63:0] = 64'h1234_5678_9abc_def0;
    req_id_i[2:0]    = 3'd1;
    req_len_i[7:0]   = 8'd3;
    req_valid_i      = 2'b01;
    #1;
    n_cmp++; if (req_ready_o !== 2'b01) begin n_bad++; $display("FAIL stable_req_ready: got %b want 01", req_ready_o); end
    step();
    req_valid_i = 2'b00;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if (ar_valid_o !== 1'b1 || ar_addr_o !== 64'h1234_5678_9abc_def0 || ar_id_o !== 4'h1 || ar_len_o !== 8'd3) begin
        n_bad++;
        $display("FAIL stable_cycle%0d: got v=%b a=%h id=%h len=%h want v=1 a=123456789abcdef0 id=1 len=03",
                 i, ar_valid_o, ar_addr_o, ar_id_o, ar_len_o);
      end
      flush_i = (i == 2);
      step();
    end
    flush_i    = 1'b0;
    ar_ready_i = 1'b1;
    #1;
    n_cmp++; if (ar_valid_o !== 1'b1) begin n_bad++; $display("FAIL stable_hold: got %b want 1", ar_valid_o); end
    step();
    ar_ready_i = 1'b0;
    #1;
    n_cmp++; if (ar_valid_o !== 1'b0) begin n_bad++; $display("FAIL stable_release: got %b want 0", ar_valid_o); end
    $display("test_ar_stable done");
  endtask

  // Runs after test_ar_stable, which leaves one port-0 burst (id 1) outstanding.
  task automatic test_flush_drain();
    req_id_i    = '0;
    req_valid_i = 2'b10;
    ar_ready_i  = 1'b1;
    #1;
    n_cmp++; if (req_ready_o !== 2'b10) begin n_bad++; $display("FAIL flush_setup_grant: got %b want 10", req_ready_o); end
    step();
    req_valid_i = 2'b00;
    step();
    flush_i     = 1'b1;
    req_valid_i = 2'b11;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (req_ready_o !== 2'b00 || ar_valid_o !== 1'b0 || drained_o !== 1'b0) begin
        n_bad++;
        $display("FAIL flush_hold%0d: got rdy=%b arv=%b drn=%b want 00 0 0", i, req_ready_o, ar_valid_o, drained_o);
      end
      step();
    end
    r_valid_i   = 1'b1;
    r_id_i      = 4'h1;
    r_last_i    = 1'b1;
    rsp_ready_i = 2'b11;
    step();
    r_id_i = 4'h8;
    #1;
    n_cmp++; if (drained_o !== 1'b0) begin n_bad++; $display("FAIL flush_one_left: drained got %b want 0", drained_o); end
    step();
    r_valid_i = 1'b0;
    r_last_i  = 1'b0;
    #1;
    n_cmp++; if (drained_o !== 1'b1) begin n_bad++; $display("FAIL flush_drained: got %b want 1", drained_o); end
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL flush_err: got %b want 0", err_o); end
    flush_i     = 1'b0;
    req_valid_i = 2'b00;
    ar_ready_i  = 1'b0;
    step();
    $display("test_flush_drain done");
  endtask

  task automatic test_zero_beat_err();
    r_valid_i   = 1'b1;
    r_id_i      = 4'h9;
    r_last_i    = 1'b0;
    rsp_ready_i = 2'b10;
    #1;
    n_cmp++; if (rsp_valid_o !== 2'b10) begin n_bad++; $display("FAIL err_rsp_valid: got %b want 10", rsp_valid_o); end
    n_cmp++; if (r_ready_o !== 1'b1) begin n_bad++; $display("FAIL err_r_ready: got %b want 1", r_ready_o); end
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL err_before: got %b want 0", err_o); end
    step();
    r_valid_i = 1'b0;
    #1;
    n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL err_set: got %b want 1", err_o); end
    step();
    step();
    step();
    n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", err_o); end
    n_cmp++; if (rsp_valid_o !== 2'b00) begin n_bad++; $display("FAIL err_rsp_idle: got %b want 00", rsp_valid_o); end
    $display("test_zero_beat_err done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_outstanding_limit();
    test_ar_stable();
    test_flush_drain();
    test_zero_beat_err();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
